// File: rtl/mistral_pkg.sv
// mistral_pkg: shared MLAB geometry constants, legality check and address type
package mistral_pkg;
    localparam int MLAB_MAX_BITS = 640;
    localparam int MLAB_DEPTHS [2] = '{32, 64};
    typedef logic [5:0] mlab_addr_t;

    function automatic bit mlab_width_ok(input int depth, input int width);
        return (depth == MLAB_DEPTHS[0] && width >= 1 && width <= 20) ||
               (depth == MLAB_DEPTHS[1] && width >= 1 && width <= 10);
    endfunction
endpackage

// File: rtl/mistral_mlab_rdreg.sv
// mistral_mlab_rdreg: MLAB read register with enable, async clear and write-forward mux
module mistral_mlab_rdreg #(
    parameter int WIDTH = 1
) (
    input  logic             CLK1,
    input  logic             ACLR,
    input  logic             en,
    input  logic             fwd,
    input  logic [WIDTH-1:0] rd_word,
    input  logic [WIDTH-1:0] wr_word,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge CLK1 or posedge ACLR)
        if (ACLR) q <= '0;
        else if (en) q <= fwd ? wr_word : rd_word;
endmodule

// File: rtl/mistral_mlab_ram.sv
// mistral_mlab_ram: Cyclone V MLAB LUT-RAM model, 32xW or 64xW, optional read register
// Define MISTRAL_MLAB_WRITE_FORWARD_EN for new-data reads on same-address collisions.
module mistral_mlab_ram
    import mistral_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 32,
    parameter int OUTREG = 0,
    parameter logic [DEPTH*WIDTH-1:0] INIT = '0
) (
    input  logic                     CLK1,
    input  logic                     ACLR,
    input  logic [$clog2(DEPTH)-1:0] A1ADDR,
    input  logic [WIDTH-1:0]         A1DATA,
    input  logic                     A1EN,
    input  logic [$clog2(DEPTH)-1:0] B1ADDR,
    input  logic                     B1EN,
    output logic [WIDTH-1:0]         B1DATA
);
    localparam int AW = $clog2(DEPTH);

    if (!mlab_width_ok(DEPTH, WIDTH) || DEPTH * WIDTH > MLAB_MAX_BITS) begin : g_bad
        $error("mistral_mlab_ram: illegal geometry DEPTH=%0d WIDTH=%0d", DEPTH, WIDTH);
    end

    // The array is never cleared; ACLR only touches the read register.
    logic [DEPTH*WIDTH-1:0] mem = INIT;
    logic [WIDTH-1:0] rd_word;
    logic fwd;

    always_ff @(posedge CLK1)
        for (int i = 0; i < DEPTH; i++)
            if (A1EN && A1ADDR == AW'(i)) mem[i*WIDTH +: WIDTH] <= A1DATA;

    assign rd_word = mem[B1ADDR*WIDTH +: WIDTH];

`ifdef MISTRAL_MLAB_WRITE_FORWARD_EN
    assign fwd = A1EN && A1ADDR == B1ADDR;
`else
    assign fwd = 1'b0;
`endif

    if (OUTREG != 0) begin : g_reg
        mistral_mlab_rdreg #(.WIDTH(WIDTH)) u_rdreg (
            .CLK1(CLK1),
            .ACLR(ACLR),
            .en(B1EN),
            .fwd(fwd),
            .rd_word(rd_word),
            .wr_word(A1DATA),
            .q(B1DATA)
        );
    end else begin : g_async
        logic unused_rd;
        assign unused_rd = B1EN ^ ACLR ^ fwd;
        assign B1DATA = rd_word;
    end
endmodule
